// File: rtl/mux_pkg.sv
// Shared types for the mux sequencer: the external mode encoding and the controller state.
package mux_pkg;

   typedef enum logic {MUX_DIRECT = 1'b0, MUX_SCAN = 1'b1} mux_mode_t;

   typedef enum logic {S_DIRECT = 1'b0, S_SCAN = 1'b1} mux_state_t;

endpackage

// File: rtl/mux_packed.sv
// Purely combinational M:1 selector over a packed bus; an index of M or above yields zero.
module mux_packed #(
   parameter  int N     = 8,
   parameter  int M     = 32,
   localparam int SEL_W = $clog2(M)
) (
   input  logic [M*N-1:0] data_i,
   input  logic [SEL_W-1:0] idx_i,
   output logic [N-1:0]   data_o
);

   // One-hot style scan of every legal channel; no match leaves the zero default.
   always_comb begin
      data_o = '0;
      for (int k = 0; k < M; k++) begin
         data_o = (int'(idx_i) == k) ? data_i[k*N +: N] : data_o;
      end
   end

endmodule

// File: rtl/mux_sequencer.sv
// Registered M-channel mux with a direct-select mode and an auto-scan mode with programmable dwell.
module mux_sequencer
   import mux_pkg::*;
#(
   parameter  int N     = 8,
   parameter  int M     = 32,
   parameter  int DWELL = 1,
   localparam int SEL_W = $clog2(M)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  mux_mode_t        mode,
   input  logic [SEL_W-1:0] select,
   input  logic [M*N-1:0]   in,
   output logic [N-1:0]     out,
   output logic [SEL_W-1:0] out_sel,
   output logic             out_valid,
   output logic             wrap
);

   localparam int               DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(M - 1);
   localparam logic [SEL_W:0]   M_LIM   = (SEL_W + 1)'(M);

   mux_state_t       state_q, state_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic [DW_W-1:0]  dw_q, dw_d;
   logic [N-1:0]     out_q, out_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;

   logic             switch_s;
   logic [SEL_W-1:0] ch_base_s;
   logic [DW_W-1:0]  dw_base_s;
   logic [SEL_W-1:0] idx_s;
   logic [N-1:0]     mux_data_s;
   logic             sel_ok_s;

   // A mode change restarts the scan position, and that edge already acts on the new mode.
   assign state_d   = (mode == MUX_SCAN) ? S_SCAN : S_DIRECT;
   assign switch_s  = (state_d != state_q);
   assign ch_base_s = switch_s ? '0 : ch_q;
   assign dw_base_s = switch_s ? '0 : dw_q;
   assign idx_s     = (state_d == S_SCAN) ? ch_base_s : select;
   assign sel_ok_s  = ({1'b0, select} < M_LIM);

   mux_packed #(.N(N), .M(M)) u_mux (
      .data_i (in),
      .idx_i  (idx_s),
      .data_o (mux_data_s)
   );

   // Next-state: output sampling plus channel/dwell stepping.
   always_comb begin
      ch_d      = ch_base_s;
      dw_d      = dw_base_s;
      out_d     = out_q;
      out_sel_d = out_sel_q;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
      if (ena) begin
         case (state_d)
            S_SCAN: begin
               out_d     = mux_data_s;
               out_sel_d = ch_base_s;
               valid_d   = 1'b1;
               if (dw_base_s == DW_LAST) begin
                  dw_d   = '0;
                  wrap_d = (ch_base_s == CH_LAST);
                  ch_d   = (ch_base_s == CH_LAST) ? '0 : ch_base_s + SEL_W'(1);
               end else begin
                  dw_d   = dw_base_s + DW_W'(1);
               end
            end
            S_DIRECT: begin
               out_d     = mux_data_s;
               out_sel_d = select;
               valid_d   = sel_ok_s;
               ch_d      = '0;
               dw_d      = '0;
            end
            default: begin
               ch_d = '0;
               dw_d = '0;
            end
         endcase
      end else begin
         out_d     = out_q;
         out_sel_d = out_sel_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_DIRECT;
         ch_q      <= '0;
         dw_q      <= '0;
         out_q     <= '0;
         out_sel_q <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         dw_q      <= dw_d;
         out_q     <= out_d;
         out_sel_q <= out_sel_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
      end
   end

   assign out       = out_q;
   assign out_sel   = out_sel_q;
   assign out_valid = valid_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_sequencer.sv
// Bench for mux_sequencer: a 32-channel and a 20-channel instance, both DWELL=2, against a position-count model.
module tb_mux_sequencer;
   import mux_pkg::*;

   localparam int N = 8, DWELL = 2, MA = 32, MB = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, ena;
   mux_mode_t  mode;
   logic [4:0] select;
   logic [7:0] dat [2][32];
   logic [MA*N-1:0] in_a;
   logic [MB*N-1:0] in_b;
   logic [7:0] out_a, out_b;
   logic [4:0] sel_a, sel_b;
   logic       valid_a, valid_b, wrap_a, wrap_b;

   int vectors = 0, miscompares = 0, wraps_a, wraps_b;

   // Reference state: scan position counted in enabled scan cycles since restart.
   int         m_pos   [2];
   mux_mode_t  m_mode  [2];
   logic [7:0] m_out   [2];
   logic [4:0] m_sel   [2];
   logic       m_valid [2];
   logic       m_wrap  [2];
   int         mcnt    [2] = '{MA, MB};

   always_comb begin
      for (int k = 0; k < MA; k++) in_a[k*N +: N] = dat[0][k];
      for (int k = 0; k < MB; k++) in_b[k*N +: N] = dat[1][k];
   end

   mux_sequencer #(.N(N), .M(MA), .DWELL(DWELL)) dut_a (
      .clk(clk), .rst(rst), .ena(ena), .mode(mode), .select(select), .in(in_a),
      .out(out_a), .out_sel(sel_a), .out_valid(valid_a), .wrap(wrap_a));

   mux_sequencer #(.N(N), .M(MB), .DWELL(DWELL)) dut_b (
      .clk(clk), .rst(rst), .ena(ena), .mode(mode), .select(select), .in(in_b),
      .out(out_b), .out_sel(sel_b), .out_valid(valid_b), .wrap(wrap_b));

   function automatic void model_edge(int u);
      int m, per, c;
      m   = mcnt[u];
      per = m * DWELL;
      if (rst) begin
         m_pos[u] = 0; m_mode[u] = MUX_DIRECT; m_out[u] = 8'd0;
         m_sel[u] = 5'd0; m_valid[u] = 1'b0; m_wrap[u] = 1'b0;
      end else begin
         if (mode != m_mode[u]) m_pos[u] = 0;
         m_mode[u]  = mode;
         m_valid[u] = 1'b0;
         m_wrap[u]  = 1'b0;
         if (ena) begin
            if (mode == MUX_DIRECT) begin
               m_sel[u] = select;
               if (int'(select) < m) begin
                  m_out[u]   = dat[u][select];
                  m_valid[u] = 1'b1;
               end else begin
                  m_out[u] = 8'd0;
               end
            end else begin
               c          = (m_pos[u] / DWELL) % m;
               m_out[u]   = dat[u][c];
               m_sel[u]   = 5'(c);
               m_valid[u] = 1'b1;
               m_wrap[u]  = ((m_pos[u] % per) == per - 1);
               m_pos[u]++;
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic e, input mux_mode_t md, input logic [4:0] s);
      rst = r; ena = e; mode = md; select = s;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      chk("a_out",   32'(out_a),   32'(m_out[0]));
      chk("a_sel",   32'(sel_a),   32'(m_sel[0]));
      chk("a_valid", 32'(valid_a), 32'(m_valid[0]));
      chk("a_wrap",  32'(wrap_a),  32'(m_wrap[0]));
      chk("b_out",   32'(out_b),   32'(m_out[1]));
      chk("b_sel",   32'(sel_b),   32'(m_sel[1]));
      chk("b_valid", 32'(valid_b), 32'(m_valid[1]));
      chk("b_wrap",  32'(wrap_b),  32'(m_wrap[1]));
   endtask

   initial begin
      for (int u = 0; u < 2; u++)
         for (int k = 0; k < 32; k++) dat[u][k] = 8'(k + 1);
      rst = 1'b1; ena = 1'b0; mode = MUX_DIRECT; select = 5'd0;

      cyc(1'b1, 1'b0, MUX_DIRECT, 5'd0);
      cyc(1'b1, 1'b1, MUX_SCAN, 5'd7);
      chk("reset_out", 32'(out_a), 32'd0);
      chk("reset_valid", 32'(valid_a), 32'd0);

      for (int s = 0; s < 32; s++) begin
         cyc(1'b0, 1'b1, MUX_DIRECT, 5'(s));
         chk("direct_out", 32'(out_a), 32'(s + 1));
         chk("direct_sel", 32'(sel_a), 32'(s));
      end

      wraps_a = 0; wraps_b = 0;
      for (int i = 0; i < 66; i++) begin
         cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
         chk("scan_out", 32'(out_a), 32'((i / 2) % 32 + 1));
         chk("scan_b_out", 32'(out_b), 32'((i / 2) % 20 + 1));
         chk("scan_wrap_at", 32'(wrap_a), 32'(i == 63));
         chk("scan_b_wrap_at", 32'(wrap_b), 32'(i == 39));
         wraps_a += int'(wrap_a);
         wraps_b += int'(wrap_b);
      end
      chk("scan_wrap_count", 32'(wraps_a), 32'd1);
      chk("scan_b_wrap_count", 32'(wraps_b), 32'd1);

      // Pause on the first dwell cycle of channel 4 (out=5).
      cyc(1'b0, 1'b1, MUX_DIRECT, 5'd0);
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
      chk("pause_pre", 32'(out_a), 32'd5);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, MUX_SCAN, 5'd0);
         chk("pause_hold", 32'(out_a), 32'd5);
         chk("pause_valid", 32'(valid_a), 32'd0);
      end
      cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
      chk("resume_1", 32'(out_a), 32'd5);
      cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
      chk("resume_2", 32'(out_a), 32'd6);

      cyc(1'b0, 1'b1, MUX_DIRECT, 5'd0);
      for (int i = 0; i < 19; i++) cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
      chk("switch_pre", 32'(out_a), 32'd10);
      cyc(1'b0, 1'b1, MUX_DIRECT, 5'd3);
      chk("switch_direct", 32'(out_a), 32'd4);
      cyc(1'b0, 1'b1, MUX_SCAN, 5'd3);
      chk("switch_rescan", 32'(out_a), 32'd1);
      chk("switch_rescan_sel", 32'(sel_a), 32'd0);

      cyc(1'b0, 1'b1, MUX_DIRECT, 5'd0);
      for (int i = 0; i < 39; i++) cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
      chk("rst_pre", 32'(out_a), 32'd20);
      cyc(1'b1, 1'b1, MUX_SCAN, 5'd0);
      chk("rst_out", 32'(out_a), 32'd0);
      chk("rst_sel", 32'(sel_a), 32'd0);
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_wrap", 32'(wrap_a), 32'd0);
      cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
      chk("rst_resume_1", 32'(out_a), 32'd1);
      cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
      chk("rst_resume_2", 32'(out_a), 32'd1);
      cyc(1'b0, 1'b1, MUX_SCAN, 5'd0);
      chk("rst_resume_3", 32'(out_a), 32'd2);

      cyc(1'b0, 1'b1, MUX_DIRECT, 5'd25);
      chk("oor_out", 32'(out_b), 32'd0);
      chk("oor_valid", 32'(valid_b), 32'd0);
      chk("oor_sel", 32'(sel_b), 32'd25);
      chk("inrange_a_out", 32'(out_a), 32'd26);

      // Randomized traffic: sticky mode, sparse resets, gaps in ena, drifting channel data.
      for (int i = 0; i < 3000; i++) begin
         mux_mode_t md;
         md = ($urandom_range(0, 15) == 0) ? ((mode == MUX_SCAN) ? MUX_DIRECT : MUX_SCAN) : mode;
         if ($urandom_range(0, 7) == 0)
            dat[$urandom_range(0, 1)][$urandom_range(0, 31)] = 8'($urandom);
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), md, 5'($urandom_range(0, 31)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
